// File: rtl/mem_trace_buffer_pkg.sv
// trace_pkg: shared FSM encoding, timestamp width and entry field offsets.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Build option: TRACE_TSTAMP_EN prepends a TS_W-bit cycle stamp to each entry.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam int TS_W = 16;

  // Entry layout, LSB first: data, addr, pc, is_write, [timestamp].
  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int pc_lsb(input int addr_w, input int data_w);
    return data_w + addr_w;
  endfunction

  function automatic int we_bit(input int pc_w, input int addr_w, input int data_w);
    return data_w + addr_w + pc_w;
  endfunction

  function automatic int ts_lsb(input int pc_w, input int addr_w, input int data_w);
    return data_w + addr_w + pc_w + 1;
  endfunction

  function automatic int entry_w(input int pc_w, input int addr_w, input int data_w);
`ifdef TRACE_TSTAMP_EN
    return TS_W + 1 + pc_w + addr_w + data_w;
`else
    return 1 + pc_w + addr_w + data_w;
`endif
  endfunction

endpackage

// File: rtl/mem_trace_buffer_if.sv
// Bundles the snooped data-memory access bus and the trace drain stream.
// Latency: n/a (wiring only).
// Backpressure: rd_valid/rd_ready handshake on the drain side; access side cannot stall.
// master: CPU/consumer side (drives acc_*, rd_ready). slave: trace buffer side.
// Build option: TRACE_TSTAMP_EN widens rd_entry by the timestamp field.
interface mem_trace_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PC_W   = 8
);
  import trace_pkg::*;

  localparam int ENTRY_W = entry_w(PC_W, ADDR_W, DATA_W);

  logic              acc_we;
  logic              acc_re;
  logic [PC_W-1:0]   acc_pc;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] acc_rdata;

  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_entry;
  logic               rd_last;

  modport master (
    output acc_we, acc_re, acc_pc, acc_addr, acc_wdata, acc_rdata,
    output rd_ready,
    input  rd_valid, rd_entry, rd_last
  );

  modport slave (
    input  acc_we, acc_re, acc_pc, acc_addr, acc_wdata, acc_rdata,
    input  rd_ready,
    output rd_valid, rd_entry, rd_last
  );

endinterface

// File: rtl/mem_trace_buffer_ram.sv
// trace_ram: DEPTH x W entry storage, synchronous write, asynchronous read.
// Latency: write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none; the caller owns all flow control.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 73
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  // No reset: contents are meaningless until counted in by the owner.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_trace_buffer.sv
// mem_trace_buffer: circular capture of data-memory accesses, stopped POST entries after a trigger write.
// Latency: a recorded access shows in count_o one cycle after its edge; drain entry is combinational from storage.
// Backpressure: drain holds rd_entry stable while rd_valid && !rd_ready; capture side never stalls.
// Ports: clk, rst (async, active high); arm pulse; trig_addr; bus (slave: acc_* snoop, rd_* stream);
//        state_o, count_o, triggered, overlap_err status.
// Build option: TRACE_TSTAMP_EN adds a free-running 16-bit cycle stamp as the entry MSBs.
module mem_trace_buffer
  import trace_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int DEPTH  = 16,
  parameter int POST   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic [ADDR_W-1:0]          trig_addr,
  mem_trace_buffer_if.slave          bus,
  output logic [1:0]                 state_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       triggered,
  output logic                       overlap_err
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int ENTRY_W  = entry_w(PC_W, ADDR_W, DATA_W);
  localparam int WE_BIT   = we_bit(PC_W, ADDR_W, DATA_W);
  localparam int PC_LSB   = pc_lsb(ADDR_W, DATA_W);
  localparam int ADDR_LSB = addr_lsb(DATA_W);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] POST_C   = PTR_W'(POST);

  trace_state_e       state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               triggered_q, triggered_d;
  logic               overlap_err_q, overlap_err_d;

  logic               rec;
  logic               is_trig;
  logic               rd_valid_w;
  logic               pop;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] ram_rdata;

`ifdef TRACE_TSTAMP_EN
  localparam int TS_LSB = ts_lsb(PC_W, ADDR_W, DATA_W);
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = arm ? '0 : ts_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end
`endif

  // A simultaneous read+write is recorded as the write only.
  always_comb begin
    wr_entry                           = '0;
    wr_entry[WE_BIT]                   = bus.acc_we;
    wr_entry[PC_LSB +: PC_W]           = bus.acc_pc;
    wr_entry[ADDR_LSB +: ADDR_W]       = bus.acc_addr;
    wr_entry[0 +: DATA_W]              = bus.acc_we ? bus.acc_wdata : bus.acc_rdata;
`ifdef TRACE_TSTAMP_EN
    wr_entry[TS_LSB +: TS_W]           = ts_q;
`endif
  end

  // Oldest entry sits count slots behind the write pointer; when full the
  // low bits of count are zero, so the oldest is the slot about to be overwritten.
  assign rd_ptr     = wr_ptr_q - count_q[PTR_W-1:0];
  assign rd_valid_w = (state_q == ST_DONE) && (count_q != '0);
  assign pop        = rd_valid_w && bus.rd_ready;
  assign rec        = ((state_q == ST_ARMED) || (state_q == ST_POST)) &&
                      (bus.acc_we || bus.acc_re) && !arm;
  assign is_trig    = bus.acc_we && (bus.acc_addr == trig_addr);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    post_cnt_d    = post_cnt_q;
    count_d       = count_q;
    triggered_d   = triggered_q;
    overlap_err_d = overlap_err_q | (bus.acc_we & bus.acc_re);

    if (arm) begin
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      post_cnt_d  = '0;
      count_d     = '0;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED, ST_POST: begin
          if (rec) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != CNT_FULL) count_d = count_q + 1'b1;
            if (state_q == ST_ARMED) begin
              if (is_trig) begin
                triggered_d = 1'b1;
                post_cnt_d  = POST_C;
                state_d     = (POST == 0) ? ST_DONE : ST_POST;
              end
            end else begin
              post_cnt_d = post_cnt_q - 1'b1;
              if (post_cnt_q == PTR_ONE) state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (pop) begin
            count_d = count_q - 1'b1;
            if (count_q == CNT_ONE) state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      post_cnt_q    <= '0;
      count_q       <= '0;
      triggered_q   <= 1'b0;
      overlap_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      post_cnt_q    <= post_cnt_d;
      count_q       <= count_d;
      triggered_q   <= triggered_d;
      overlap_err_q <= overlap_err_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (rec),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Entry is forced to zero when nothing is offered so idle/reset output is clean.
  assign bus.rd_valid = rd_valid_w;
  assign bus.rd_entry = rd_valid_w ? ram_rdata : '0;
  assign bus.rd_last  = rd_valid_w && (count_q == CNT_ONE);

  assign state_o     = state_q;
  assign count_o     = count_q;
  assign triggered   = triggered_q;
  assign overlap_err = overlap_err_q;

endmodule

// File: tb/tb_mem_trace_buffer.sv
// Bench for mem_trace_buffer (DEPTH=8, POST=2): vector table, directed corner sequences,
// and randomized capture/drain rounds scored against a queue-based reference model.
// Entry comparisons ignore the optional timestamp field.
module tb_mem_trace_buffer;
  import trace_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int PC_W   = 8;
  localparam int DEPTH  = 8;
  localparam int POST   = 2;
  localparam int E0     = 1 + PC_W + ADDR_W + DATA_W;
  localparam logic [31:0] TRIG = 32'd4;

  logic clk = 1'b0;
  logic rst;
  logic arm;
  logic [ADDR_W-1:0] trig_addr;
  logic [1:0] state_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  logic triggered;
  logic overlap_err;

  mem_trace_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  mem_trace_buffer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .POST(POST)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_addr(trig_addr), .bus(bus),
    .state_o(state_o), .count_o(count_o), .triggered(triggered), .overlap_err(overlap_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [7:0]  pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic a, we, re;
    logic [31:0] addr, wd, rd;
    logic [3:0] e_cnt;
    logic [1:0] e_st;
    logic e_trig;
  } vec_t;

  // Reference model: the captured window as a queue, plus mode bookkeeping.
  ent_t mq[$];
  int   mstate;
  int   mpost;
  logic mtrig;
  logic movl;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic we, input logic [7:0] pc,
                                      input logic [31:0] addr, input logic [31:0] data);
    ent_t e;
    e.we = we; e.pc = pc; e.addr = addr; e.data = data;
    return 128'(e);
  endfunction

  function automatic vec_t v(input int a, input int we, input int re, input int addr,
                             input int wd, input int rd, input int cnt, input int st, input int tr);
    vec_t r;
    r.a = a[0]; r.we = we[0]; r.re = re[0];
    r.addr = addr; r.wd = wd; r.rd = rd;
    r.e_cnt = 4'(cnt); r.e_st = 2'(st); r.e_trig = tr[0];
    return r;
  endfunction

  function automatic void m_arm();
    mq.delete();
    mstate = 1;
    mpost  = 0;
    mtrig  = 1'b0;
  endfunction

  function automatic void m_access(input logic we, input logic re, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rd, input logic [7:0] pc);
    ent_t e;
    if (!(we || re)) return;
    if (mstate != 1 && mstate != 2) return;
    e.we = we; e.pc = pc; e.addr = addr; e.data = we ? wd : rd;
    mq.push_back(e);
    if (mq.size() > DEPTH) void'(mq.pop_front());
    if (mstate == 1) begin
      if (we && addr == TRIG) begin
        mtrig  = 1'b1;
        mpost  = POST;
        mstate = (POST == 0) ? 3 : 2;
      end
    end else begin
      mpost--;
      if (mpost == 0) mstate = 3;
    end
  endfunction

  task automatic cyc(input logic a, input logic we, input logic re, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rd, input logic [7:0] pc);
    arm = a;
    bus.acc_we = we; bus.acc_re = re; bus.acc_addr = addr;
    bus.acc_wdata = wd; bus.acc_rdata = rd; bus.acc_pc = pc;
    @(posedge clk);
    if (we && re) movl = 1'b1;
    if (a) m_arm();
    else   m_access(we, re, addr, wd, rd, pc);
    #1;
    arm = 1'b0; bus.acc_we = 1'b0; bus.acc_re = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, " count"}, 128'(count_o), 128'(mq.size()));
    chk({tag, " state"}, 128'(state_o), 128'(mstate));
    chk({tag, " trig"},  128'(triggered), 128'(mtrig));
    chk({tag, " ovl"},   128'(overlap_err), 128'(movl));
    chk({tag, " valid"}, 128'(bus.rd_valid), 128'(mstate == 3 && mq.size() != 0));
  endtask

  task automatic drain(input bit rand_ready, input string tag);
    int n;
    logic rdy;
    n = 0;
    while (mstate == 3 && mq.size() != 0 && n < 300) begin
      rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.rd_ready = rdy;
      chk({tag, " rd_valid"}, 128'(bus.rd_valid), 128'(1));
      chk({tag, " entry"}, 128'(bus.rd_entry[E0-1:0]), 128'(mq[0]));
      chk({tag, " rd_last"}, 128'(bus.rd_last), 128'(mq.size() == 1));
      @(posedge clk);
      if (rdy) begin
        void'(mq.pop_front());
        if (mq.size() == 0) mstate = 0;
      end
      #1;
      n++;
    end
    bus.rd_ready = 1'b0;
    if (mstate == 3) begin
      total++; bad++;
      $display("FAIL %s drain timeout: got state %0d want 0", tag, state_o);
    end
    chk({tag, " end state"}, 128'(state_o), 128'(0));
    chk({tag, " end count"}, 128'(count_o), 128'(0));
  endtask

  vec_t vt[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = v(1, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[1] = v(0, 0, 1, 0, 0, 5, 1, 1, 0);
    vt[2] = v(0, 0, 1, 1, 0, 3, 2, 1, 0);
    vt[3] = v(0, 0, 1, 2, 0, 8, 3, 1, 0);
    vt[4] = v(0, 0, 1, 3, 0, 1, 4, 1, 0);
    vt[5] = v(0, 1, 0, 4, 7, 0, 5, 2, 1);
    vt[6] = v(0, 0, 1, 1, 0, 9, 6, 2, 1);
    vt[7] = v(0, 0, 1, 2, 0, 6, 7, 3, 1);

    rst = 1'b1; arm = 1'b0; trig_addr = TRIG;
    bus.acc_we = 1'b0; bus.acc_re = 1'b0; bus.acc_pc = '0; bus.acc_addr = '0;
    bus.acc_wdata = '0; bus.acc_rdata = '0; bus.rd_ready = 1'b0;
    mq.delete(); mstate = 0; mpost = 0; mtrig = 1'b0; movl = 1'b0;

    // Reset
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst state", 128'(state_o), 128'(0));
    chk("rst count", 128'(count_o), 128'(0));
    chk("rst valid", 128'(bus.rd_valid), 128'(0));
    chk("rst last",  128'(bus.rd_last), 128'(0));
    chk("rst entry", 128'(bus.rd_entry), 128'(0));
    chk("rst trig",  128'(triggered), 128'(0));
    chk("rst ovl",   128'(overlap_err), 128'(0));
    cyc(0, 1, 0, TRIG, 32'h11, 0, 8'h01);
    cyc(0, 0, 1, 32'h3, 0, 32'h22, 8'h02);
    chk("idle count", 128'(count_o), 128'(0));
    chk("idle state", 128'(state_o), 128'(0));
    chk("idle trig",  128'(triggered), 128'(0));

    // Vector table: basic capture with trigger in the middle
    for (int i = 0; i < 8; i++) begin
      cyc(vt[i].a, vt[i].we, vt[i].re, vt[i].addr, vt[i].wd, vt[i].rd, 8'(i));
      chk($sformatf("vec%0d count", i), 128'(count_o), 128'(vt[i].e_cnt));
      chk($sformatf("vec%0d state", i), 128'(state_o), 128'(vt[i].e_st));
      chk($sformatf("vec%0d trig", i),  128'(triggered), 128'(vt[i].e_trig));
    end
    chk("vec first entry", 128'(bus.rd_entry[E0-1:0]), mk(1'b0, 8'd1, 32'd0, 32'd5));
    drain(1'b0, "vec");

    // Wrap with backpressure
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 32'(i), 0, 32'(100 + i), 8'(i));
    cyc(0, 1, 0, TRIG, 32'd77, 0, 8'd12);
    cyc(0, 0, 1, 32'd12, 0, 32'd112, 8'd13);
    cyc(0, 0, 1, 32'd13, 0, 32'd113, 8'd14);
    chk("wrap count", 128'(count_o), 128'(8));
    chk("wrap state", 128'(state_o), 128'(3));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp entry", 128'(bus.rd_entry[E0-1:0]), mk(1'b0, 8'd7, 32'd7, 32'd107));
      chk("bp count", 128'(count_o), 128'(8));
    end
    for (int i = 0; i < 5; i++) begin
      bus.rd_ready = 1'b1;
      @(posedge clk); #1;
      void'(mq.pop_front());
    end
    bus.rd_ready = 1'b0;
    chk("wrap 6th is trigger", 128'(bus.rd_entry[E0-1:0]), mk(1'b1, 8'd12, TRIG, 32'd77));
    chk("wrap count after 5", 128'(count_o), 128'(3));
    drain(1'b0, "wrap");

    // Simultaneous read and write
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'd9, 32'hAA, 32'hBB, 8'h33);
    chk("ovl count", 128'(count_o), 128'(1));
    chk("ovl flag",  128'(overlap_err), 128'(1));
    cyc(0, 1, 0, TRIG, 32'h5, 0, 8'h34);
    cyc(0, 0, 1, 32'd1, 0, 32'h6, 8'h35);
    cyc(0, 0, 1, 32'd2, 0, 32'h7, 8'h36);
    chk_status("ovl");
    chk("ovl entry", 128'(bus.rd_entry[E0-1:0]), mk(1'b1, 8'h33, 32'd9, 32'hAA));
    drain(1'b0, "ovl");
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("ovl sticky", 128'(overlap_err), 128'(1));

    // Re-arm during post-trigger phase
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'd0, 0, 32'h40, 8'd1);
    cyc(0, 0, 1, 32'd1, 0, 32'h41, 8'd2);
    cyc(0, 1, 0, TRIG, 32'h42, 0, 8'd3);
    chk("rearm post state", 128'(state_o), 128'(2));
    cyc(1, 0, 1, 32'd50, 0, 32'h99, 8'd4);
    chk("rearm state", 128'(state_o), 128'(1));
    chk("rearm count", 128'(count_o), 128'(0));
    chk("rearm trig",  128'(triggered), 128'(0));
    cyc(0, 0, 1, 32'd20, 0, 32'h50, 8'd5);
    cyc(0, 0, 1, 32'd21, 0, 32'h51, 8'd6);
    cyc(0, 1, 0, TRIG, 32'h52, 0, 8'd7);
    cyc(0, 0, 1, 32'd22, 0, 32'h53, 8'd8);
    cyc(0, 0, 1, 32'd23, 0, 32'h54, 8'd9);
    chk("rearm done count", 128'(count_o), 128'(5));
    chk("rearm done state", 128'(state_o), 128'(3));
    chk("rearm first", 128'(bus.rd_entry[E0-1:0]), mk(1'b0, 8'd5, 32'd20, 32'h50));
    drain(1'b0, "rearm");

    // Randomized rounds
    for (int r = 0; r < 15; r++) begin
      int k;
      cyc(1, 0, 0, 0, 0, 0, 0);
      k = 0;
      while (mstate != 3 && k < 60) begin
        int op;
        logic [31:0] a, wd, rd;
        logic [7:0] pc;
        op = $urandom_range(0, 19);
        a  = $urandom_range(0, 7);
        wd = $urandom;
        rd = $urandom;
        pc = 8'($urandom);
        if (op <= 2)       cyc(0, 0, 0, a, wd, rd, pc);
        else if (op <= 10) cyc(0, 0, 1, a, wd, rd, pc);
        else if (op <= 17) cyc(0, 1, 0, a, wd, rd, pc);
        else if (op == 18) cyc(0, 1, 1, a, wd, rd, pc);
        else               cyc(1, 0, 0, a, wd, rd, pc);
        chk_status($sformatf("rnd%0d", r));
        k++;
      end
      if (mstate == 1) cyc(0, 1, 0, TRIG, $urandom, 0, 8'hEE);
      k = 0;
      while (mstate != 3 && k < 10) begin
        cyc(0, 0, 1, $urandom_range(0, 7), 0, $urandom, 8'hEF);
        k++;
      end
      chk_status($sformatf("rnd%0d done", r));
      drain(1'b1, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_trace_buffer.md
Name: mem_trace_buffer

Overview:
- Parametrised, synthesizable capture block for CPU data-memory traffic. It records each data-memory read or write from riscv_top into a circular trace buffer.
- Recording stops after a programmable post-trigger count once a trigger fires.
- The stored window is then drained oldest-first over a valid/ready stream.
- Sits beside data_memory on the ram_addr/W_en/R_en/Wr_mem_data/Rd_mem_data nets. It replaces $monitor-style observation with on-chip capture.

Parameters:
- ADDR_W, 32, access address width
- DATA_W, 32, data width
- PC_W, 8, width of the PC (rom_addr) tag
- DEPTH, 16, number of entries; power of two, at least 4
- POST, 4, entries recorded after the trigger entry; must satisfy 0 <= POST <= DEPTH-1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle pulse; clears the buffer and starts capture
- trig_addr  in  ADDR_W  a write to this address is the trigger
- acc_we  in  1  data-memory write strobe
- acc_re  in  1  data-memory read strobe
- acc_pc  in  PC_W  PC of the accessing instruction
- acc_addr  in  ADDR_W  access address
- acc_wdata  in  DATA_W  write data
- acc_rdata  in  DATA_W  read data, valid in the same cycle
- state_o  out  2  current FSM state
- count_o  out  $clog2(DEPTH+1)  valid entries held
- triggered  out  1  trigger seen since the last arm
- overlap_err  out  1  sticky; set when acc_we and acc_re are high together
- rd_valid  out  1  entry available
- rd_ready  in  1  consumer accepts the entry
- rd_entry  out  ENTRY_W  entry layout is {is_write, pc, addr, data}; ENTRY_W = 1+PC_W+ADDR_W+DATA_W
- rd_last  out  1  asserted with the final entry

Behaviour:
- Reset values:
  - state IDLE (0); wr_ptr, rd_ptr, count, post_cnt = 0.
  - triggered, overlap_err, rd_valid, rd_last = 0; rd_entry = 0.
- Recording an access:
  - An access is any cycle with acc_we|acc_re, sampled at the clk edge.
  - The entry is written at wr_ptr; wr_ptr increments mod DEPTH. count increments, saturating at DEPTH.
  - At saturation the oldest entry is overwritten and the read base advances with it.
  - data field = acc_wdata if acc_we, else acc_rdata.
  - If acc_we and acc_re are both high, only the write entry is recorded and overlap_err is set. overlap_err clears only on rst.
- arm in any state: next state ARMED; pointers, count and triggered cleared. Any access in the arm cycle is discarded.
- IDLE: accesses ignored.
- ARMED: records every access.
  - Trigger = acc_we && acc_addr==trig_addr. The trigger entry is itself recorded, triggered=1, post_cnt=POST.
  - Next state is DONE if POST==0, otherwise POST.
  - A read of trig_addr is not a trigger.
- POST: records accesses; post_cnt decrements per recorded entry. The entry recorded when post_cnt==1 moves the FSM to DONE.
- DONE:
  - Accesses ignored; rd_ptr = (wr_ptr - count) mod DEPTH, i.e. the oldest entry.
  - rd_valid = (count != 0). rd_entry is driven from the buffer at rd_ptr and held stable while rd_valid && !rd_ready.
  - On rd_valid && rd_ready: rd_ptr+1 mod DEPTH, count-1.
  - rd_last = rd_valid && count==1. After the last pop, next state is IDLE.
- Latency: a recorded access is reflected in count_o one cycle after its edge.
- rst mid-capture or mid-drain returns everything to reset values immediately; buffer contents become don't-care.

Optional Feature:
- Macro: TRACE_TSTAMP_EN.
- When defined:
  - A free-running cycle counter TS_W=16 bits, cleared by rst and by arm, is prepended to each entry.
  - ENTRY_W grows by 16; wraps mod 2^16 with no flag.
- When undefined: no counter, and the layout is exactly as above.

Decomposition:
- Package trace_pkg holds:
  - state encodings IDLE=2'd0, ARMED=2'd1, POST=2'd2, DONE=2'd3;
  - a TS_W=16 constant;
  - entry field offset functions parametrised by PC_W/ADDR_W/DATA_W.
- One sub-module, trace_ram: DEPTH x ENTRY_W, synchronous write, asynchronous read. It holds the storage; the FSM and pointers stay in the top.

Test Plan:
- rst high for 2 cycles, then low -> state_o=0, count_o=0, rd_valid=0, all flags 0; accesses before arm leave count_o=0.
- DEPTH=8, POST=2, trig_addr=4:
  - Stimulus: arm; reads of addrs 0..3 (rdata 5,3,8,1); write addr 4 data 7; reads of addrs 1,2.
  - Response: DONE with count_o=7. Drain yields entries in that order, starting with is_write=0 addr 0 data 5. rd_last is on the 7th entry, then state_o=0.
- Wrap, DEPTH=8, POST=2:
  - Stimulus: 12 reads of addrs 0..11, trigger write addr 4, 2 more reads.
  - Response: count_o=8; first drained entry is the read of addr 7, and the trigger write is the 6th entry.
- Backpressure: in DONE hold rd_ready=0 for 3 cycles -> rd_entry and count_o unchanged; rd_ready=1 then pops one entry per cycle.
- acc_we=acc_re=1 at addr 9 in ARMED -> one entry with is_write=1 and data=wdata; overlap_err=1 and still 1 after a later arm.
- arm pulsed while in POST -> next cycle state_o=1, count_o=0, triggered=0; the earlier pre-trigger entries are never drained.
